// File: rtl/alarm_clock_ctrl.sv
// rtl/alarm_clock_ctrl.sv - alarm clock sequencer: running time, set-time/set-alarm editing, ring control
// Optional snooze re-trigger is built when ALARM_CLOCK_SNOOZE_EN is defined.
module alarm_clock_ctrl #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick_1hz,
  input  logic       i_mode_btn,
  input  logic       i_sel_btn,
  input  logic       i_inc_btn,
  input  logic       i_alarm_en,
  input  logic       i_snooze_btn,
  output logic [2:0] o_state,
  output logic [1:0] o_field,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic [4:0] o_s_hours,
  output logic [5:0] o_s_minutes,
  output logic [5:0] o_s_seconds,
  output logic [4:0] o_a_hours,
  output logic [5:0] o_a_minutes,
  output logic [5:0] o_a_seconds,
  output logic       o_ring
);

  typedef enum logic [2:0] {
    ST_NORMAL    = 3'b000,
    ST_SET_TIME  = 3'b010,
    ST_SET_ALARM = 3'b100,
    ST_RING      = 3'b110
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_field, w_field_nxt;
  logic [4:0] r_hours, r_s_hours, r_a_hours;
  logic [5:0] r_minutes, r_seconds, r_s_minutes, r_s_seconds, r_a_minutes, r_a_seconds;
  logic [4:0] w_hours_nxt, w_s_hours_nxt, w_a_hours_nxt;
  logic [5:0] w_minutes_nxt, w_seconds_nxt, w_s_minutes_nxt, w_s_seconds_nxt;
  logic [5:0] w_a_minutes_nxt, w_a_seconds_nxt;
  logic [7:0] r_ring_cnt, w_ring_cnt_nxt;
  logic       r_ring, w_ring_nxt;
  logic [4:0] w_tk_hours;
  logic [5:0] w_tk_minutes, w_tk_seconds;
  logic       w_mode, w_sel, w_inc;
  logic       w_alarm_hit, w_snz_hit, w_snz_press, w_ring_done, w_ring_exit;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [1:0] next_field(input logic [1:0] f);
    return (f == 2'd2) ? 2'd0 : f + 2'd1;
  endfunction

  // Running time one second ahead, with full carry chain.
  always_comb begin
    w_tk_seconds = inc60(r_seconds);
    w_tk_minutes = r_minutes;
    w_tk_hours   = r_hours;
    if (r_seconds == 6'd59) begin
      w_tk_minutes = inc60(r_minutes);
      if (r_minutes == 6'd59) begin
        w_tk_hours = inc24(r_hours);
      end
    end
  end

  assign w_mode = i_mode_btn;
  assign w_sel  = i_sel_btn & ~i_mode_btn;
  assign w_inc  = i_inc_btn & ~i_mode_btn & ~i_sel_btn;

  assign w_alarm_hit = (r_state == ST_NORMAL) && i_alarm_en && i_tick_1hz &&
                       (w_tk_hours == r_a_hours) && (w_tk_minutes == r_a_minutes) &&
                       (w_tk_seconds == r_a_seconds);
  assign w_ring_done = i_tick_1hz && (r_ring_cnt == 8'(RING_SECS - 1));
  assign w_ring_exit = w_snz_press | i_mode_btn | i_sel_btn | i_inc_btn |
                       ~i_alarm_en | w_ring_done;

`ifdef ALARM_CLOCK_SNOOZE_EN
  logic [4:0] r_snz_hours, w_snz_hours_nxt, w_tgt_hours;
  logic [5:0] r_snz_minutes, r_snz_seconds, w_snz_minutes_nxt, w_snz_seconds_nxt, w_tgt_minutes;
  logic       r_snz_valid, w_snz_valid_nxt;
  logic [6:0] w_min_sum;

  assign w_snz_press = (r_state == ST_RING) && i_snooze_btn;
  assign w_snz_hit   = (r_state == ST_NORMAL) && i_alarm_en && i_tick_1hz && r_snz_valid &&
                       (w_tk_hours == r_snz_hours) && (w_tk_minutes == r_snz_minutes) &&
                       (w_tk_seconds == r_snz_seconds);

  always_comb begin
    w_min_sum     = {1'b0, r_minutes} + 7'(SNOOZE_MIN);
    w_tgt_hours   = r_hours;
    w_tgt_minutes = w_min_sum[5:0];
    if (w_min_sum >= 7'd60) begin
      w_tgt_minutes = 6'(w_min_sum - 7'd60);
      w_tgt_hours   = inc24(r_hours);
    end
  end

  // alarm_en low overrides everything, including a snooze loaded this cycle.
  always_comb begin
    w_snz_hours_nxt   = r_snz_hours;
    w_snz_minutes_nxt = r_snz_minutes;
    w_snz_seconds_nxt = r_snz_seconds;
    w_snz_valid_nxt   = r_snz_valid;
    if (w_snz_press) begin
      w_snz_hours_nxt   = w_tgt_hours;
      w_snz_minutes_nxt = w_tgt_minutes;
      w_snz_seconds_nxt = r_seconds;
      w_snz_valid_nxt   = 1'b1;
    end
    if (w_snz_hit) w_snz_valid_nxt = 1'b0;
    if ((r_state == ST_NORMAL) && w_mode) w_snz_valid_nxt = 1'b0;
    if (!i_alarm_en) w_snz_valid_nxt = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_snz_hours   <= '0;
      r_snz_minutes <= '0;
      r_snz_seconds <= '0;
      r_snz_valid   <= 1'b0;
    end else begin
      r_snz_hours   <= w_snz_hours_nxt;
      r_snz_minutes <= w_snz_minutes_nxt;
      r_snz_seconds <= w_snz_seconds_nxt;
      r_snz_valid   <= w_snz_valid_nxt;
    end
  end
`else
  logic w_unused;
  assign w_snz_press = 1'b0;
  assign w_snz_hit   = 1'b0;
  assign w_unused    = i_snooze_btn;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_NORMAL;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        if (w_mode)                        w_state_nxt = ST_SET_TIME;
        else if (w_alarm_hit || w_snz_hit) w_state_nxt = ST_RING;
      end
      ST_SET_TIME:  if (w_mode)      w_state_nxt = ST_SET_ALARM;
      ST_SET_ALARM: if (w_mode)      w_state_nxt = ST_NORMAL;
      ST_RING:      if (w_ring_exit) w_state_nxt = ST_NORMAL;
      default:                       w_state_nxt = ST_NORMAL;
    endcase
  end

  // A commit on mode_btn overrides the tick applied just above it.
  always_comb begin
    w_hours_nxt     = r_hours;
    w_minutes_nxt   = r_minutes;
    w_seconds_nxt   = r_seconds;
    w_s_hours_nxt   = r_s_hours;
    w_s_minutes_nxt = r_s_minutes;
    w_s_seconds_nxt = r_s_seconds;
    w_a_hours_nxt   = r_a_hours;
    w_a_minutes_nxt = r_a_minutes;
    w_a_seconds_nxt = r_a_seconds;
    w_field_nxt     = r_field;
    if (i_tick_1hz) begin
      w_hours_nxt   = w_tk_hours;
      w_minutes_nxt = w_tk_minutes;
      w_seconds_nxt = w_tk_seconds;
    end
    case (r_state)
      ST_NORMAL: begin
        if (w_mode) begin
          w_s_hours_nxt   = r_hours;
          w_s_minutes_nxt = r_minutes;
          w_s_seconds_nxt = r_seconds;
          w_field_nxt     = 2'd0;
        end
      end
      ST_SET_TIME: begin
        if (w_mode) begin
          w_hours_nxt   = r_s_hours;
          w_minutes_nxt = r_s_minutes;
          w_seconds_nxt = r_s_seconds;
          w_field_nxt   = 2'd0;
        end else if (w_sel) begin
          w_field_nxt = next_field(r_field);
        end else if (w_inc) begin
          case (r_field)
            2'd0:    w_s_hours_nxt   = inc24(r_s_hours);
            2'd1:    w_s_minutes_nxt = inc60(r_s_minutes);
            2'd2:    w_s_seconds_nxt = inc60(r_s_seconds);
            default: w_s_seconds_nxt = r_s_seconds;
          endcase
        end
      end
      ST_SET_ALARM: begin
        if (w_sel) begin
          w_field_nxt = next_field(r_field);
        end else if (w_inc) begin
          case (r_field)
            2'd0:    w_a_hours_nxt   = inc24(r_a_hours);
            2'd1:    w_a_minutes_nxt = inc60(r_a_minutes);
            2'd2:    w_a_seconds_nxt = inc60(r_a_seconds);
            default: w_a_seconds_nxt = r_a_seconds;
          endcase
        end
      end
      default: w_field_nxt = r_field;
    endcase
    w_ring_nxt = (w_state_nxt == ST_RING);
    if (w_state_nxt != ST_RING)                   w_ring_cnt_nxt = '0;
    else if ((r_state == ST_RING) && i_tick_1hz)  w_ring_cnt_nxt = r_ring_cnt + 8'd1;
    else                                          w_ring_cnt_nxt = r_ring_cnt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hours     <= '0;
      r_minutes   <= '0;
      r_seconds   <= '0;
      r_s_hours   <= '0;
      r_s_minutes <= '0;
      r_s_seconds <= '0;
      r_a_hours   <= '0;
      r_a_minutes <= '0;
      r_a_seconds <= '0;
      r_field     <= '0;
      r_ring_cnt  <= '0;
      r_ring      <= 1'b0;
    end else begin
      r_hours     <= w_hours_nxt;
      r_minutes   <= w_minutes_nxt;
      r_seconds   <= w_seconds_nxt;
      r_s_hours   <= w_s_hours_nxt;
      r_s_minutes <= w_s_minutes_nxt;
      r_s_seconds <= w_s_seconds_nxt;
      r_a_hours   <= w_a_hours_nxt;
      r_a_minutes <= w_a_minutes_nxt;
      r_a_seconds <= w_a_seconds_nxt;
      r_field     <= w_field_nxt;
      r_ring_cnt  <= w_ring_cnt_nxt;
      r_ring      <= w_ring_nxt;
    end
  end

  assign o_state     = r_state;
  assign o_field     = r_field;
  assign o_hours     = r_hours;
  assign o_minutes   = r_minutes;
  assign o_seconds   = r_seconds;
  assign o_s_hours   = r_s_hours;
  assign o_s_minutes = r_s_minutes;
  assign o_s_seconds = r_s_seconds;
  assign o_a_hours   = r_a_hours;
  assign o_a_minutes = r_a_minutes;
  assign o_a_seconds = r_a_seconds;
  assign o_ring      = r_ring;

endmodule
